// File: rtl/dpm_stream_if.sv
// Handshake bundle for dpm_stream: job control, load stream, result stream and status.
interface dpm_stream_if #(
  parameter int DATA_W = 16
);
  logic                     start;
  logic                     bypass_mode;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     done;
  logic                     sat_flag;

  modport master (
    output start, bypass_mode, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy, done, sat_flag
  );

  modport slave (
    input  start, bypass_mode, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy, done, sat_flag
  );
endinterface

// File: rtl/dpm_stream.sv
// Deformable tile filter: loads weights, per-tap offsets and a reference tile, then emits
// OUT_W x OUT_W weighted sums of bilinear samples (or tap-centre pixels in bypass).
module dpm_stream #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 40,
  parameter int FRAC_BITS = 8,
  parameter int K         = 3,
  parameter int TILE      = 8
) (
  input logic         clk,
  input logic         rst,
  dpm_stream_if.slave bus
);
  localparam int OUT_W  = TILE - K + 1;
  localparam int NTAP   = K * K;
  localparam int NREF   = TILE * TILE;
  localparam int TAP_AW = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int REF_AW = (NREF > 1) ? $clog2(NREF) : 1;
  localparam int CNT_W  = $clog2(NREF + 2 * NTAP + 1);
  localparam int TW     = $clog2(K + 1);
  localparam int PW     = $clog2(TILE + 1);
  localparam int SW     = DATA_W + 2 * FRAC_BITS + 6;
  localparam int CTR    = K / 2;
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((longint'(1) <<< (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  typedef enum logic [2:0] {StIdle, StLoadWt, StLoadOff, StLoadRef, StCompute, StEmit} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]            ti_q, ti_d, tj_q, tj_d;
  logic [PW-1:0]            ox_q, ox_d, oy_q, oy_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] res_q, res_d;
  logic                     bypass_q, bypass_d, sat_q, sat_d, done_q, done_d;

  logic signed [DATA_W-1:0] wt_mem   [NTAP];
  logic signed [DATA_W-1:0] offx_mem [NTAP];
  logic signed [DATA_W-1:0] offy_mem [NTAP];
  logic signed [DATA_W-1:0] ref_mem  [NREF];

  logic                     in_rdy, take, last_tap, last_pix, sat_hit;
  logic [TAP_AW-1:0]        tap_idx;
  logic signed [DATA_W-1:0] offx_t, offy_t, sat_val, byp_val;
  int                       px, py;
  logic signed [SW-1:0]     v00, v01, v10, v11, fxw, fyw, sxw, syw, sum, samp;
  logic signed [ACC_W-1:0]  acc_nxt, acc_sh;

  // Coordinates outside the tile read as zero rather than clamping to the edge.
  function automatic logic signed [DATA_W-1:0] ref_at(input int x, input int y);
    if (x < 0 || y < 0 || x >= TILE || y >= TILE) return '0;
    return ref_mem[REF_AW'(y * TILE + x)];
  endfunction

  assign in_rdy = (state_q == StLoadWt) || (state_q == StLoadOff) || (state_q == StLoadRef);
  assign take   = bus.in_valid && in_rdy;

  always_comb begin
    tap_idx = TAP_AW'(int'(ti_q) * K + int'(tj_q));
    offx_t  = offx_mem[tap_idx];
    offy_t  = offy_mem[tap_idx];
    px      = int'(ox_q) + int'(tj_q) + int'(offx_t >>> FRAC_BITS);
    py      = int'(oy_q) + int'(ti_q) + int'(offy_t >>> FRAC_BITS);
    fxw     = SW'(offx_t[FRAC_BITS-1:0]);
    fyw     = SW'(offy_t[FRAC_BITS-1:0]);
    sxw     = SW'(1 <<< FRAC_BITS) - fxw;
    syw     = SW'(1 <<< FRAC_BITS) - fyw;
    v00     = SW'(ref_at(px, py));
    v01     = SW'(ref_at(px + 1, py));
    v10     = SW'(ref_at(px, py + 1));
    v11     = SW'(ref_at(px + 1, py + 1));
    sum     = v00 * sxw * syw + v01 * fxw * syw + v10 * sxw * fyw + v11 * fxw * fyw
            + (SW'(1) <<< (2 * FRAC_BITS - 1));
    samp    = sum >>> (2 * FRAC_BITS);
    acc_nxt = acc_q + ACC_W'(samp) * ACC_W'(wt_mem[tap_idx]);
    acc_sh  = acc_nxt >>> FRAC_BITS;
    sat_hit = 1'b0;
    if (acc_sh > MAX_V) begin
      sat_val = MAX_V[DATA_W-1:0];
      sat_hit = 1'b1;
    end else if (acc_sh < MIN_V) begin
      sat_val = MIN_V[DATA_W-1:0];
      sat_hit = 1'b1;
    end else begin
      sat_val = acc_sh[DATA_W-1:0];
    end
    byp_val  = ref_at(int'(ox_q) + CTR, int'(oy_q) + CTR);
    last_tap = (ti_q == TW'(K - 1)) && (tj_q == TW'(K - 1));
    last_pix = (ox_q == PW'(OUT_W - 1)) && (oy_q == PW'(OUT_W - 1));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ti_d     = ti_q;
    tj_d     = tj_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    acc_d    = acc_q;
    res_d    = res_q;
    bypass_d = bypass_q;
    sat_d    = sat_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StLoadWt;
          cnt_d    = '0;
          bypass_d = bus.bypass_mode;
          sat_d    = 1'b0;
        end
      end
      StLoadWt: begin
        if (take) begin
          if (cnt_q == CNT_W'(NTAP - 1)) begin
            cnt_d   = '0;
            state_d = StLoadOff;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StLoadOff: begin
        if (take) begin
          if (cnt_q == CNT_W'(2 * NTAP - 1)) begin
            cnt_d   = '0;
            state_d = StLoadRef;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StLoadRef: begin
        if (take) begin
          if (cnt_q == CNT_W'(NREF - 1)) begin
            cnt_d   = '0;
            ox_d    = '0;
            oy_d    = '0;
            ti_d    = '0;
            tj_d    = '0;
            acc_d   = '0;
            state_d = bypass_q ? StEmit : StCompute;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StCompute: begin
        acc_d = acc_nxt;
        if (tj_q == TW'(K - 1)) begin
          tj_d = '0;
          ti_d = ti_q + TW'(1);
        end else tj_d = tj_q + TW'(1);
        if (last_tap) begin
          ti_d    = '0;
          res_d   = sat_val;
          sat_d   = sat_q | sat_hit;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          acc_d = '0;
          if (last_pix) begin
            ox_d    = '0;
            oy_d    = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            if (ox_q == PW'(OUT_W - 1)) begin
              ox_d = '0;
              oy_d = oy_q + PW'(1);
            end else ox_d = ox_q + PW'(1);
            state_d = bypass_q ? StEmit : StCompute;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ti_q     <= '0;
      tj_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      bypass_q <= 1'b0;
      sat_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ti_q     <= ti_d;
      tj_q     <= tj_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      bypass_q <= bypass_d;
      sat_q    <= sat_d;
      done_q   <= done_d;
    end
  end

  // Coefficient and tile storage is reloaded by every job, so it carries no reset.
  always_ff @(posedge clk) begin
    if (take) begin
      case (state_q)
        StLoadWt: wt_mem[TAP_AW'(cnt_q)] <= bus.in_data;
        StLoadOff: begin
          if (cnt_q < CNT_W'(NTAP)) offx_mem[TAP_AW'(cnt_q)] <= bus.in_data;
          else offy_mem[TAP_AW'(cnt_q - CNT_W'(NTAP))] <= bus.in_data;
        end
        StLoadRef: ref_mem[REF_AW'(cnt_q)] <= bus.in_data;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == StEmit);
  assign bus.out_data  = (state_q == StEmit) ? (bypass_q ? byp_val : res_q) : '0;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_dpm_stream.sv
// Bench for dpm_stream: table of tile jobs checked against an arithmetic reference model,
// plus hand-written reset sequences.
module tb_dpm_stream;
  localparam int DATA_W = 16, ACC_W = 40, FRAC_BITS = 8, K = 3, TILE = 8;
  localparam int OUT_W = TILE - K + 1, NT = K * K, NP = OUT_W * OUT_W, NREF = TILE * TILE;

  typedef struct {
    int pat;
    bit byp, gaps, stall, hold, bp, chk;
    int first, last;
    bit sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dpm_stream_if #(.DATA_W(DATA_W)) bus ();

  dpm_stream #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS), .K(K), .TILE(TILE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int wt_a[NT], offx_a[NT], offy_a[NT], ref_a[NREF];
  int exp_a[NP];
  bit exp_sat;
  vec_t tbl[9];

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint rd(input int x, input int y);
    if (x < 0 || y < 0 || x >= TILE || y >= TILE) return 0;
    return longint'(ref_a[y * TILE + x]);
  endfunction

  // Reference: direct evaluation of the bilinear-sample / weighted-sum definition.
  task automatic model(input bit byp);
    longint acc, r, s, v00, v01, v10, v11, fx, fy;
    int t, dx, dy, bx, by;
    exp_sat = 0;
    for (int oy = 0; oy < OUT_W; oy++) begin
      for (int ox = 0; ox < OUT_W; ox++) begin
        if (byp) r = rd(ox + K / 2, oy + K / 2);
        else begin
          acc = 0;
          for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
              t  = i * K + j;
              fx = offx_a[t] & 255;
              fy = offy_a[t] & 255;
              dx = (offx_a[t] - int'(fx)) / 256;
              dy = (offy_a[t] - int'(fy)) / 256;
              bx = ox + j + dx;
              by = oy + i + dy;
              v00 = rd(bx, by);
              v01 = rd(bx + 1, by);
              v10 = rd(bx, by + 1);
              v11 = rd(bx + 1, by + 1);
              s = v00 * (256 - fx) * (256 - fy) + v01 * fx * (256 - fy)
                + v10 * (256 - fx) * fy + v11 * fx * fy + 32768;
              s = s >>> 16;
              acc += longint'(wt_a[t]) * s;
            end
          end
          r = acc >>> 8;
          if (r > 32767) begin r = 32767; exp_sat = 1; end
          if (r < -32768) begin r = -32768; exp_sat = 1; end
        end
        exp_a[oy * OUT_W + ox] = int'(r);
      end
    end
  endtask

  task automatic set_pattern(input int p);
    logic [15:0] r16;
    for (int t = 0; t < NT; t++) begin wt_a[t] = 0; offx_a[t] = 0; offy_a[t] = 0; end
    for (int i = 0; i < NREF; i++) ref_a[i] = i;  // ref[y][x] = x + TILE*y
    case (p)
      0: wt_a[NT / 2] = 256;
      1: begin
        wt_a[NT / 2] = 256;
        for (int t = 0; t < NT; t++) offx_a[t] = 128;
      end
      2: begin wt_a[0] = 256; offx_a[0] = -512; end
      3: begin
        for (int t = 0; t < NT; t++) wt_a[t] = 256;
        for (int i = 0; i < NREF; i++) ref_a[i] = 32767;
      end
      default: begin
        for (int t = 0; t < NT; t++) begin
          wt_a[t]   = int'($urandom_range(0, 1024)) - 512;
          offx_a[t] = int'($urandom_range(0, 1200)) - 600;
          offy_a[t] = int'($urandom_range(0, 1200)) - 600;
        end
        for (int i = 0; i < NREF; i++) begin
          r16 = 16'($urandom);
          ref_a[i] = int'($signed(r16));
        end
      end
    endcase
  endtask

  task automatic start_job(input bit byp);
    bus.bypass_mode = byp;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bypass_mode = 1'b0;
    check("busy after start", bus.busy, 1);
    check("sat_flag cleared on start", bus.sat_flag, 0);
    check("in_ready in load", bus.in_ready, 1);
  endtask

  task automatic load_words(input bit gaps, input bit hold);
    int words[$];
    int n;
    foreach (wt_a[t]) words.push_back(wt_a[t]);
    foreach (offx_a[t]) words.push_back(offx_a[t]);
    foreach (offy_a[t]) words.push_back(offy_a[t]);
    foreach (ref_a[i]) words.push_back(ref_a[i]);
    if (hold) bus.start = 1'b1;
    foreach (words[w]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin bus.in_valid = 1'b0; @(posedge clk); #1; end
      end
      bus.in_valid = 1'b1;
      bus.in_data = DATA_W'(words[w]);
      n = 0;
      while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) check("in_ready wait", 0, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, " out_valid"}, bus.out_valid, 0);
    check({nm, " out_data"}, $signed(bus.out_data), 0);
    check({nm, " in_ready"}, bus.in_ready, 0);
    check({nm, " busy"}, bus.busy, 0);
    check({nm, " done"}, bus.done, 0);
    check({nm, " sat_flag"}, bus.sat_flag, 0);
  endtask

  task automatic run_job(input string nm, input vec_t v);
    int lat, got, cyc;
    int got_a[NP];
    set_pattern(v.pat);
    model(v.byp);
    start_job(v.byp);
    load_words(v.gaps, v.hold);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check({nm, " first-output latency"}, lat, v.byp ? 1 : NT + 1);
    check({nm, " in_ready low in emit"}, bus.in_ready, 0);
    if (v.stall) begin
      bus.out_ready = 1'b0;
      repeat (5) begin
        @(posedge clk); #1;
        check({nm, " stall out_valid"}, bus.out_valid, 1);
        check({nm, " stall out_data"}, $signed(bus.out_data), exp_a[0]);
      end
    end
    got = 0;
    cyc = 0;
    while (got < NP && cyc < 4000) begin
      bus.out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        got_a[got] = int'($signed(bus.out_data));
        check($sformatf("%s pixel %0d", nm, got), got_a[got], exp_a[got]);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready = 1'b1;
    check({nm, " pixel count"}, got, NP);
    check({nm, " done after last accept"}, bus.done, 1);
    check({nm, " idle after last accept"}, bus.busy, 0);
    check({nm, " sat_flag"}, bus.sat_flag, exp_sat);
    if (v.chk) begin
      check({nm, " first pixel"}, got_a[0], v.first);
      check({nm, " last pixel"}, got_a[NP - 1], v.last);
      check({nm, " sat_flag constant"}, bus.sat_flag, v.sat);
    end
    @(posedge clk); #1;
    check({nm, " done one cycle"}, bus.done, 0);
    check({nm, " sat_flag sticky"}, bus.sat_flag, exp_sat);
  endtask

  initial begin
    int n;
    //          pat byp gap stl hld bp chk first  last  sat
    tbl[0] = '{0, 0, 0, 1, 0, 0, 1, 9, 54, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 1, 10, 55, 0};
    tbl[2] = '{2, 0, 0, 0, 0, 0, 1, 0, 43, 0};
    tbl[3] = '{3, 0, 0, 0, 0, 0, 1, 32767, 32767, 1};
    tbl[4] = '{0, 1, 0, 0, 0, 0, 1, 9, 54, 0};
    tbl[5] = '{0, 0, 1, 0, 1, 1, 1, 9, 54, 0};
    tbl[6] = '{4, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[7] = '{4, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[8] = '{4, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    bus.start = 1'b0;
    bus.bypass_mode = 1'b0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    #1 check_reset_outs("power-on reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i]) run_job($sformatf("job%0d", i), tbl[i]);

    // Reset while a saturated pixel is being held in EMIT.
    set_pattern(3);
    start_job(0);
    load_words(0, 0);
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 200) begin @(posedge clk); #1; n++; end
    check("emit-reset presented pixel", $signed(bus.out_data), 32767);
    check("emit-reset sat before reset", bus.sat_flag, 1);
    #2 rst = 1'b1;
    #1 check_reset_outs("emit-reset async");
    @(posedge clk); #1;
    check_reset_outs("emit-reset held");
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("emit-reset stays idle", bus.busy, 0);

    // Reset in the middle of the tap loop, then a full job must reproduce the base results.
    set_pattern(0);
    start_job(0);
    load_words(0, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("compute-reset busy before", bus.busy, 1);
    check("compute-reset no output yet", bus.out_valid, 0);
    #2 rst = 1'b1;
    #1 check_reset_outs("compute-reset async");
    @(posedge clk); #1;
    rst = 1'b0;
    run_job("rerun", tbl[4].byp ? '{0, 0, 0, 0, 0, 0, 1, 9, 54, 0} : tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
